load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WAIT_MAX, default 255: timeout limit in cycles (used only with LSU_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  datapath request strobe, sampled only in IDLE.
REQ-005 ld  in  1  load request (lw/lbu/lhu).
REQ-006 ll  in  1  load-linked request.
REQ-007 MemWr  in  3  store type: 001 sw, 010 sb, 100 sh, 011 sc; 000 none.
REQ-008 DMcut_sel  in  2  load width: 00 word, 01 byte unsigned, 10 half unsigned.
REQ-009 addr  in  32  byte address; wdata  in  32  store data.
REQ-010 rdata  out  32  load result, or SC status (1 success, 0 fail).
REQ-011 done  out  1  one-cycle completion pulse; err  out  1  valid with done.
REQ-012 busy  out  1  high whenever state is not IDLE (datapath stall).
REQ-013 mem_req, mem_we  out  1; mem_be  out  4; mem_addr, mem_wdata  out  32; mem_rdata, mem_ack  in  32/1.

Function
REQ-014 FSM states IDLE, REQ, DONE; start in IDLE with a legal op latches addr/wdata/op, next state REQ.
REQ-015 Legal op: exactly one of {ld, ll, MemWr!=0}; MemWr in {001,010,100,011}; anything else -> DONE, err=1, no memory access.
REQ-016 Alignment: word ops need addr[1:0]=00, sh/lhu need addr[0]=0; violation -> DONE, err=1, no access.
REQ-017 In REQ: mem_req=1, mem_addr={addr[31:2],2'b00}, held stable until mem_ack sampled high; then DONE.
REQ-018 Byte lanes little-endian: sb mem_be=1<<addr[1:0], mem_wdata={4{wdata[7:0]}}; sh mem_be=addr[1]?1100:0011, mem_wdata={2{wdata[15:0]}}; sw/sc mem_be=1111.
REQ-019 Loads: mem_we=0, mem_be=1111; rdata captured on ack, lane-selected by addr[1:0], zero-extended for lbu/lhu.
REQ-020 ll: performs word load; sets reservation valid and res_addr=addr[31:2].
REQ-021 sc: if reservation valid and res_addr matches, perform word store, rdata=1; else no access, go directly DONE, rdata=0, err=0; reservation cleared either way.
REQ-022 sw/sb/sh whose word address matches res_addr clears reservation on completion.
REQ-023 DONE lasts exactly one cycle (done=1), then IDLE; minimum latency start->done is 2 cycles with same-cycle ack in REQ.
REQ-024 start while busy ignored; mem_ack outside REQ ignored.

Reset
REQ-025 rst_n low at an edge: state IDLE, mem_req=0, mem_we=0, mem_be=0, done=0, err=0, busy=0, rdata=0, reservation cleared; abort of in-flight request is permitted mid-REQ.

Configuration
REQ-026 Macro LSU_TIMEOUT_EN defined: counter in REQ; WAIT_MAX cycles without ack -> drop mem_req, DONE with err=1, reservation cleared.
REQ-027 LSU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for mem_ack.

Verification
REQ-028 lbu addr=0x1003, mem_rdata=0xAABBCCDD, ack after 3 cycles -> mem_addr=0x1000, rdata=0x000000AA, done once.
REQ-029 sh addr=0x2002 wdata=0x1234 -> mem_we=1, mem_be=1100, mem_wdata=0x12341234; sh addr=0x2001 -> err=1, mem_req never high.
REQ-030 ll 0x3000, then sc 0x3000 -> store issued, rdata=1; second sc 0x3000 -> no mem_req, rdata=0.
REQ-031 ll 0x4000, sb 0x4002, sc 0x4000 -> sc fails, rdata=0.
REQ-032 rst_n low during REQ -> next edge mem_req=0, busy=0; following sc fails.
REQ-033 With LSU_TIMEOUT_EN, WAIT_MAX=4, no ack -> mem_req drops after 4 REQ cycles, done=1, err=1.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the datapath and a
// word-wide memory port. Handles lw/lbu/lhu/ll and sw/sb/sh/sc, little-endian byte lanes,
// alignment and legality checks, and a one-entry LL/SC reservation.
// Build option: define LSU_TIMEOUT_EN to abort a request after WAIT_MAX cycles without
// mem_ack. Without it, a request waits for mem_ack indefinitely.
module load_store_unit #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ld,
    input  logic        ll,
    input  logic [2:0]  MemWr,
    input  logic [1:0]  DMcut_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
    typedef enum logic [2:0] {OpLw, OpLbu, OpLhu, OpLl, OpSw, OpSb, OpSh, OpSc} op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_dec;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        err_q;
    logic        res_valid_q;
    logic [29:0] res_addr_q;
    logic        op_legal, op_aligned, sc_hit, req_ok;
    logic        timeout;
    logic [31:0] load_data;

    // Decode the request strobes into a single operation and check legality.
    always_comb begin
        op_dec   = OpLw;
        op_legal = 1'b0;
        if (ld && !ll && MemWr == 3'b000) begin
            op_legal = 1'b1;
            case (DMcut_sel)
                2'b00:   op_dec = OpLw;
                2'b01:   op_dec = OpLbu;
                2'b10:   op_dec = OpLhu;
                default: op_legal = 1'b0;
            endcase
        end else if (ll && !ld && MemWr == 3'b000) begin
            op_dec   = OpLl;
            op_legal = 1'b1;
        end else if (!ld && !ll) begin
            op_legal = 1'b1;
            case (MemWr)
                3'b001:  op_dec = OpSw;
                3'b010:  op_dec = OpSb;
                3'b100:  op_dec = OpSh;
                3'b011:  op_dec = OpSc;
                default: op_legal = 1'b0;
            endcase
        end
    end

    // Alignment check for the decoded operation, and the SC reservation hit test.
    always_comb begin
        case (op_dec)
            OpLbu, OpSb: op_aligned = 1'b1;
            OpLhu, OpSh: op_aligned = ~addr[0];
            default:     op_aligned = (addr[1:0] == 2'b00);
        endcase
        sc_hit = res_valid_q && (res_addr_q == addr[31:2]);
        // A failing SC completes without touching memory.
        req_ok = op_legal && op_aligned && ((op_dec != OpSc) || sc_hit);
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    logic [CntW-1:0] wait_q;

    // Count REQ cycles without ack; cleared whenever the FSM is outside REQ.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != StReq) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + CntW'(1);
        end
    end

    assign timeout = (state_q == StReq) && !mem_ack && (wait_q == CntW'(WAIT_MAX - 1));
`else
    logic unused_wait_max;
    assign unused_wait_max = ^WAIT_MAX;
    assign timeout         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = req_ok ? StReq : StDone;
            StReq:   if (mem_ack || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Select and zero-extend the addressed lanes of the returned word.
    always_comb begin
        case (op_q)
            OpLbu:   load_data = {24'h0, mem_rdata[{addr_q[1:0], 3'b000} +: 8]};
            OpLhu:   load_data = {16'h0, addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // Outputs: status flags and the memory port, driven only while in REQ.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        err       = done && err_q;
        rdata     = rdata_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (state_q == StReq) begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[31:2], 2'b00};
            case (op_q)
                OpSw, OpSc: begin
                    mem_we    = 1'b1;
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
                OpSb: begin
                    mem_we    = 1'b1;
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                OpSh: begin
                    mem_we    = 1'b1;
                    mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: mem_be = 4'b1111;
            endcase
        end
    end

    // Request latch, result capture and LL/SC reservation tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= OpLw;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= 30'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        op_q    <= op_dec;
                        err_q   <= ~(op_legal && op_aligned);
                        // Any accepted SC consumes the reservation, hit or miss.
                        if (op_legal && op_aligned && op_dec == OpSc) begin
                            res_valid_q <= 1'b0;
                            if (!sc_hit) rdata_q <= 32'h0;
                        end
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        case (op_q)
                            OpLw, OpLbu, OpLhu: rdata_q <= load_data;
                            OpLl: begin
                                rdata_q     <= load_data;
                                res_valid_q <= 1'b1;
                                res_addr_q  <= addr_q[31:2];
                            end
                            OpSc:    rdata_q <= 32'd1;
                            default: begin
                                // Plain store into the reserved word breaks the link.
                                if (res_addr_q == addr_q[31:2]) res_valid_q <= 1'b0;
                            end
                        endcase
                    end else if (timeout) begin
                        err_q       <= 1'b1;
                        res_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane handling, alignment, LL/SC, reset abort.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ld = 1'b0;
    logic        ll = 1'b0;
    logic [2:0]  MemWr = 3'b000;
    logic [1:0]  DMcut_sel = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        done, err, busy, mem_req, mem_we;
    logic [3:0]  mem_be;

    int total = 0;
    int bad = 0;

    // Observations of the most recent operation.
    int          obs_req, obs_done;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_err, obs_unstable, obs_busy_after;

    always #5 clk = ~clk;

    load_store_unit #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ld(ld), .ll(ll), .MemWr(MemWr),
        .DMcut_sel(DMcut_sel), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
        .err(err), .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Present one request for one cycle; starts and ends at a negedge.
    task automatic issue(input logic l, input logic k, input logic [2:0] mw,
                         input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
        ld = l; ll = k; MemWr = mw; DMcut_sel = sel; addr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ld = 1'b0; ll = 1'b0; MemWr = 3'b000;
    endtask

    // Act as memory: ack after ack_delay REQ cycles; record what the DUT does.
    task automatic run_op(input int ack_delay);
        bit fin = 0;
        obs_req = 0; obs_done = 0; obs_unstable = 0; obs_busy_after = 1'b1;
        obs_addr = 32'h0; obs_wdata = 32'h0; obs_be = 4'h0; obs_we = 1'b0;
        obs_err = 1'b0; obs_rdata = 32'h0;
        for (int i = 0; i < 40 && !fin; i++) begin
            if (mem_req) begin
                if (obs_req == 0) begin
                    obs_addr = mem_addr; obs_we = mem_we; obs_be = mem_be; obs_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_be, mem_wdata} !==
                             {obs_addr, obs_we, obs_be, obs_wdata}) begin
                    obs_unstable = 1'b1;
                end
                obs_req++;
                mem_ack = (obs_req > ack_delay);
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                obs_done++; obs_err = err; obs_rdata = rdata;
            end else if (obs_done > 0) begin
                fin = 1; obs_busy_after = busy;
            end
            if (!fin) @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)
            begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)
            begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (err !== 1'b0)
            begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (mem_req !== 1'b0)
            begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        total++; if (mem_we !== 1'b0)
            begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        total++; if (mem_be !== 4'b0000)
            begin bad++; $display("FAIL rst_mem_be got=%b exp=0000", mem_be); end
        total++; if (rdata !== 32'h0)
            begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lbu();
        mem_rdata = 32'hAABBCCDD;
        issue(1'b1, 1'b0, 3'b000, 2'b01, 32'h0000_1003, 32'h0);
        run_op(3);
        total++; if (obs_addr !== 32'h0000_1000)
            begin bad++; $display("FAIL lbu_addr got=%h exp=00001000", obs_addr); end
        total++; if ({obs_we, obs_be} !== 5'b0_1111)
            begin bad++; $display("FAIL lbu_we_be got=%b exp=01111", {obs_we, obs_be}); end
        total++; if (obs_req !== 4)
            begin bad++; $display("FAIL lbu_req_cycles got=%0d exp=4", obs_req); end
        total++; if (obs_unstable !== 1'b0)
            begin bad++; $display("FAIL lbu_stable got=%b exp=0", obs_unstable); end
        total++; if (obs_done !== 1)
            begin bad++; $display("FAIL lbu_done_count got=%0d exp=1", obs_done); end
        total++; if (obs_rdata !== 32'h0000_00AA)
            begin bad++; $display("FAIL lbu_rdata got=%h exp=000000aa", obs_rdata); end
        total++; if (obs_err !== 1'b0)
            begin bad++; $display("FAIL lbu_err got=%b exp=0", obs_err); end
        total++; if (obs_busy_after !== 1'b0)
            begin bad++; $display("FAIL lbu_busy_after got=%b exp=0", obs_busy_after); end
    endtask

    task automatic test_loads();
        mem_rdata = 32'hCAFEBABE;
        issue(1'b1, 1'b0, 3'b000, 2'b10, 32'h0000_6002, 32'h0);
        run_op(0);
        total++; if (obs_rdata !== 32'h0000_CAFE)
            begin bad++; $display("FAIL lhu_hi_rdata got=%h exp=0000cafe", obs_rdata); end
        total++; if (obs_req !== 1)
            begin bad++; $display("FAIL lhu_req_cycles got=%0d exp=1", obs_req); end
        issue(1'b1, 1'b0, 3'b000, 2'b01, 32'h0000_6001, 32'h0);
        run_op(0);
        total++; if (obs_rdata !== 32'h0000_00BA)
            begin bad++; $display("FAIL lbu_b1_rdata got=%h exp=000000ba", obs_rdata); end
        mem_rdata = 32'h89ABCDEF;
        issue(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_6004, 32'h0);
        run_op(1);
        total++; if (obs_rdata !== 32'h89AB_CDEF)
            begin bad++; $display("FAIL lw_rdata got=%h exp=89abcdef", obs_rdata); end
        total++; if (obs_addr !== 32'h0000_6004)
            begin bad++; $display("FAIL lw_addr got=%h exp=00006004", obs_addr); end
    endtask

    task automatic test_sh();
        issue(1'b0, 1'b0, 3'b100, 2'b00, 32'h0000_2002, 32'hDEAD_1234);
        run_op(1);
        total++; if ({obs_we, obs_be} !== 5'b1_1100)
            begin bad++; $display("FAIL sh_we_be got=%b exp=11100", {obs_we, obs_be}); end
        total++; if (obs_wdata !== 32'h1234_1234)
            begin bad++; $display("FAIL sh_wdata got=%h exp=12341234", obs_wdata); end
        total++; if (obs_addr !== 32'h0000_2000)
            begin bad++; $display("FAIL sh_addr got=%h exp=00002000", obs_addr); end
        total++; if ({obs_done, obs_err} !== {32'd1, 1'b0})
            begin bad++; $display("FAIL sh_done_err got=%0d/%b exp=1/0", obs_done, obs_err); end
        issue(1'b0, 1'b0, 3'b100, 2'b00, 32'h0000_2001, 32'h0000_1234);
        run_op(0);
        total++; if (obs_req !== 0)
            begin bad++; $display("FAIL sh_misalign_req got=%0d exp=0", obs_req); end
        total++; if ({obs_done, obs_err} !== {32'd1, 1'b1})
            begin bad++; $display("FAIL sh_misalign_err got=%0d/%b exp=1/1", obs_done, obs_err); end
    endtask

    task automatic test_errors();
        issue(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_6001, 32'h0);
        run_op(0);
        total++; if ({obs_req, obs_err} !== {32'd0, 1'b1})
            begin bad++; $display("FAIL lw_misalign got=%0d/%b exp=0/1", obs_req, obs_err); end
        issue(1'b1, 1'b1, 3'b000, 2'b00, 32'h0000_6000, 32'h0);
        run_op(0);
        total++; if ({obs_req, obs_err} !== {32'd0, 1'b1})
            begin bad++; $display("FAIL ld_ll_both got=%0d/%b exp=0/1", obs_req, obs_err); end
        issue(1'b0, 1'b0, 3'b110, 2'b00, 32'h0000_6000, 32'h0);
        run_op(0);
        total++; if ({obs_req, obs_err} !== {32'd0, 1'b1})
            begin bad++; $display("FAIL memwr_110 got=%0d/%b exp=0/1", obs_req, obs_err); end
        issue(1'b1, 1'b0, 3'b000, 2'b11, 32'h0000_6000, 32'h0);
        run_op(0);
        total++; if ({obs_req, obs_err} !== {32'd0, 1'b1})
            begin bad++; $display("FAIL ld_sel_11 got=%0d/%b exp=0/1", obs_req, obs_err); end
    endtask

    task automatic test_ll_sc();
        mem_rdata = 32'h1122_3344;
        issue(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_3000, 32'h0);
        run_op(0);
        total++; if (obs_rdata !== 32'h1122_3344)
            begin bad++; $display("FAIL ll_rdata got=%h exp=11223344", obs_rdata); end
        total++; if ({obs_we, obs_be} !== 5'b0_1111)
            begin bad++; $display("FAIL ll_we_be got=%b exp=01111", {obs_we, obs_be}); end
        issue(1'b0, 1'b0, 3'b011, 2'b00, 32'h0000_3000, 32'h0000_0055);
        run_op(0);
        total++; if (obs_req !== 1)
            begin bad++; $display("FAIL sc1_req got=%0d exp=1", obs_req); end
        total++; if ({obs_we, obs_be, obs_wdata} !== {5'b1_1111, 32'h55})
            begin bad++; $display("FAIL sc1_store got=%b/%h exp=11111/55", {obs_we, obs_be},
                                   obs_wdata); end
        total++; if ({obs_rdata, obs_err} !== {32'd1, 1'b0})
            begin bad++; $display("FAIL sc1_status got=%h/%b exp=1/0", obs_rdata, obs_err); end
        issue(1'b0, 1'b0, 3'b011, 2'b00, 32'h0000_3000, 32'h0000_0066);
        run_op(0);
        total++; if (obs_req !== 0)
            begin bad++; $display("FAIL sc2_req got=%0d exp=0", obs_req); end
        total++; if ({obs_done, obs_rdata, obs_err} !== {32'd1, 32'd0, 1'b0})
            begin bad++; $display("FAIL sc2_status got=%0d/%h/%b exp=1/0/0", obs_done,
                                   obs_rdata, obs_err); end
    endtask

    task automatic test_ll_store_sc();
        issue(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_4000, 32'h0);
        run_op(0);
        issue(1'b0, 1'b0, 3'b010, 2'b00, 32'h0000_4002, 32'h0000_007F);
        run_op(0);
        total++; if ({obs_we, obs_be} !== 5'b1_0100)
            begin bad++; $display("FAIL sb_we_be got=%b exp=10100", {obs_we, obs_be}); end
        total++; if (obs_wdata !== 32'h7F7F_7F7F)
            begin bad++; $display("FAIL sb_wdata got=%h exp=7f7f7f7f", obs_wdata); end
        issue(1'b0, 1'b0, 3'b011, 2'b00, 32'h0000_4000, 32'h0000_0001);
        run_op(0);
        total++; if ({obs_req, obs_rdata} !== {32'd0, 32'd0})
            begin bad++; $display("FAIL sc_after_sb got=%0d/%h exp=0/0", obs_req, obs_rdata); end
        // A store to a different word leaves the reservation intact.
        issue(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_4000, 32'h0);
        run_op(0);
        issue(1'b0, 1'b0, 3'b010, 2'b00, 32'h0000_4004, 32'h0000_0011);
        run_op(0);
        issue(1'b0, 1'b0, 3'b011, 2'b00, 32'h0000_4000, 32'h0000_0022);
        run_op(0);
        total++; if ({obs_req, obs_rdata} !== {32'd1, 32'd1})
            begin bad++; $display("FAIL sc_other_word got=%0d/%h exp=1/1", obs_req, obs_rdata); end
    endtask

    task automatic test_reset_mid_req();
        issue(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_5000, 32'h0);
        run_op(0);
        issue(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_5000, 32'h0);
        @(negedge clk);
        total++; if (mem_req !== 1'b1)
            begin bad++; $display("FAIL abort_pre_req got=%b exp=1", mem_req); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({mem_req, busy, done} !== 3'b000)
            begin bad++; $display("FAIL abort_state got=%b exp=000", {mem_req, busy, done}); end
        total++; if (rdata !== 32'h0)
            begin bad++; $display("FAIL abort_rdata got=%h exp=0", rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b011, 2'b00, 32'h0000_5000, 32'h0000_0099);
        run_op(0);
        total++; if ({obs_req, obs_rdata} !== {32'd0, 32'd0})
            begin bad++; $display("FAIL abort_sc got=%0d/%h exp=0/0", obs_req, obs_rdata); end
    endtask

    task automatic test_busy_ignore();
        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({busy, done, mem_req} !== 3'b000)
            begin bad++; $display("FAIL idle_ack got=%b exp=000", {busy, done, mem_req}); end
        mem_ack = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        issue(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_7000, 32'h0);
        start = 1'b1; MemWr = 3'b001; addr = 32'h0000_7100;
        @(negedge clk);
        start = 1'b0; MemWr = 3'b000;
        total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h0000_7000})
            begin bad++; $display("FAIL busy_start got=%b%b/%h exp=10/00007000", mem_req, mem_we,
                                   mem_addr); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        total++; if ({done, rdata} !== {1'b1, 32'h0BAD_F00D})
            begin bad++; $display("FAIL busy_done got=%b/%h exp=1/0badf00d", done, rdata); end
        @(negedge clk);
        total++; if ({busy, done, mem_req} !== 3'b000)
            begin bad++; $display("FAIL busy_after got=%b exp=000", {busy, done, mem_req}); end
    endtask

    task automatic test_back_to_back();
        mem_rdata = 32'h0000_0100;
        issue(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0100, 32'h0);
        run_op(0);
        total++; if ({obs_req, obs_rdata} !== {32'd1, 32'h100})
            begin bad++; $display("FAIL b2b_first got=%0d/%h exp=1/100", obs_req, obs_rdata); end
        mem_rdata = 32'h0000_0104;
        issue(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0104, 32'h0);
        run_op(0);
        total++; if ({obs_req, obs_done, obs_rdata} !== {32'd1, 32'd1, 32'h104})
            begin bad++; $display("FAIL b2b_second got=%0d/%0d/%h exp=1/1/104", obs_req, obs_done,
                                   obs_rdata); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        issue(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_8000, 32'h0);
        run_op(100);
        total++; if (obs_req !== 4)
            begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=4", obs_req); end
        total++; if ({obs_done, obs_err} !== {32'd1, 1'b1})
            begin bad++; $display("FAIL timeout_err got=%0d/%b exp=1/1", obs_done, obs_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_lbu();
        test_loads();
        test_sh();
        test_errors();
        test_ll_sc();
        test_ll_store_sc();
        test_reset_mid_req();
        test_busy_ignore();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
